// File: rtl/arrow_scheduler.sv
// arrow_scheduler: pattern-table driven attack-wave sequencer.
// Fetches one ROM entry per arrow, waits its programmed delay, then launches the
// arrow into the lowest-index free slot. Reports completion once the wave has
// drained.
`timescale 1ns / 1ps

module arrow_scheduler #(
  parameter int unsigned NUM_SLOTS   = 24,
  parameter int unsigned WAVE_DEPTH  = 16,
  parameter int unsigned TICK_CYCLES = 1083333,
  parameter int unsigned ROM_LATENCY = 2,
  parameter logic [3:0]  START_STATE = 4'b1000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        state_in,
  input  logic [3:0]                        turn_in,
  input  logic                              abort_in,
  input  logic [NUM_SLOTS-1:0]              slot_busy_in,
  output logic [3+$clog2(WAVE_DEPTH):0]     pat_addr_out,
  input  logic [13:0]                       pat_data_in,
  output logic [NUM_SLOTS-1:0]              spawn_out,
  output logic [1:0]                        direction_out,
  output logic [1:0]                        speed_out,
  output logic                              inversed_out,
  output logic                              busy_out,
  output logic                              finished_out,
  output logic [7:0]                        spawn_count_out
);

  localparam int unsigned IdxW   = $clog2(WAVE_DEPTH);
  // Delay counter must hold 255 ticks without overflow.
  localparam int unsigned CntW   = $clog2(255 * TICK_CYCLES + 1);
  localparam int unsigned FetchW = (ROM_LATENCY > 0) ? $clog2(ROM_LATENCY + 1) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StDelay, StIssue, StDrain} state_e;

  state_e               state_q, state_d;
  logic [3:0]           prev_state_q;
  logic [3:0]           turn_q, turn_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [FetchW-1:0]    fetch_cnt_q, fetch_cnt_d;
  logic [CntW-1:0]      delay_q, delay_d;
  logic [13:0]          entry_q, entry_d;
  logic                 drain_wait_q, drain_wait_d;
  logic [NUM_SLOTS-1:0] spawn_q, spawn_d;
  logic [1:0]           dir_q, dir_d;
  logic [1:0]           speed_q, speed_d;
  logic                 inv_q, inv_d;
  logic                 busy_q, busy_d;
  logic                 fin_q, fin_d;
  logic [7:0]           count_q, count_d;

  logic                 start_edge;
  logic [NUM_SLOTS-1:0] free_slots;
  logic [NUM_SLOTS-1:0] pick;
  logic                 slot_found;
  logic                 fetch_done;
  logic                 last_entry;
  logic                 drain_done;

  assign start_edge = (state_in == START_STATE) && (prev_state_q != START_STATE);
  // A slot spawned last cycle is not yet reflected in slot_busy_in.
  assign free_slots = ~slot_busy_in & ~spawn_q;
  // Isolate the lowest set bit.
  assign pick       = free_slots & (~free_slots + NUM_SLOTS'(1));
  assign slot_found = |free_slots;
  assign fetch_done = (fetch_cnt_q == FetchW'(ROM_LATENCY));
  assign last_entry = entry_q[0] || (idx_q == IdxW'(WAVE_DEPTH - 1));
  assign drain_done = drain_wait_q && (slot_busy_in == '0);

  assign pat_addr_out    = {turn_q, idx_q};
  assign spawn_out       = spawn_q;
  assign direction_out   = dir_q;
  assign speed_out       = speed_q;
  assign inversed_out    = inv_q;
  assign busy_out        = busy_q;
  assign finished_out    = fin_q;
  assign spawn_count_out = count_q;

  // State register and previous game-state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      prev_state_q <= 4'b0000;
    end else begin
      state_q      <= state_d;
      prev_state_q <= state_in;
    end
  end

  // Next-state logic; abort wins over start and launch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_edge && !abort_in) state_d = StFetch;
      StFetch: if (fetch_done) state_d = StDelay;
      StDelay: if (delay_q == '0) state_d = StIssue;
      StIssue: if (slot_found) state_d = last_entry ? StDrain : StFetch;
      StDrain: if (drain_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_in && (state_q != StIdle)) state_d = StIdle;
  end

  // Datapath and registered-output next values.
  always_comb begin
    turn_d       = turn_q;
    idx_d        = idx_q;
    fetch_cnt_d  = fetch_cnt_q;
    delay_d      = delay_q;
    entry_d      = entry_q;
    drain_wait_d = drain_wait_q;
    busy_d       = busy_q;
    count_d      = count_q;
    spawn_d      = '0;
    dir_d        = 2'b00;
    speed_d      = 2'b00;
    inv_d        = 1'b0;
    fin_d        = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_edge && !abort_in) begin
          turn_d      = turn_in;
          idx_d       = '0;
          fetch_cnt_d = '0;
          count_d     = 8'd0;
          busy_d      = 1'b1;
        end
      end
      StFetch: begin
        if (fetch_done) begin
          entry_d = pat_data_in;
          delay_d = CntW'(pat_data_in[13:6]) * CntW'(TICK_CYCLES);
        end else begin
          fetch_cnt_d = fetch_cnt_q + FetchW'(1);
        end
      end
      StDelay: begin
        if (delay_q != '0) delay_d = delay_q - CntW'(1);
      end
      StIssue: begin
        if (slot_found) begin
          spawn_d = pick;
          dir_d   = entry_q[5:4];
          speed_d = entry_q[3:2];
          inv_d   = entry_q[1];
          count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          if (last_entry) begin
            drain_wait_d = 1'b0;
          end else begin
            idx_d       = idx_q + IdxW'(1);
            fetch_cnt_d = '0;
          end
        end
      end
      StDrain: begin
        if (!drain_wait_q) begin
          drain_wait_d = 1'b1;
        end else if (drain_done) begin
          fin_d  = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (abort_in && (state_q != StIdle)) begin
      busy_d  = 1'b0;
      spawn_d = '0;
      dir_d   = 2'b00;
      speed_d = 2'b00;
      inv_d   = 1'b0;
      fin_d   = 1'b0;
      count_d = count_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      turn_q       <= 4'd0;
      idx_q        <= '0;
      fetch_cnt_q  <= '0;
      delay_q      <= '0;
      entry_q      <= 14'd0;
      drain_wait_q <= 1'b0;
      spawn_q      <= '0;
      dir_q        <= 2'b00;
      speed_q      <= 2'b00;
      inv_q        <= 1'b0;
      busy_q       <= 1'b0;
      fin_q        <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      turn_q       <= turn_d;
      idx_q        <= idx_d;
      fetch_cnt_q  <= fetch_cnt_d;
      delay_q      <= delay_d;
      entry_q      <= entry_d;
      drain_wait_q <= drain_wait_d;
      spawn_q      <= spawn_d;
      dir_q        <= dir_d;
      speed_q      <= speed_d;
      inv_q        <= inv_d;
      busy_q       <= busy_d;
      fin_q        <= fin_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_arrow_scheduler.sv
// Self-checking bench for arrow_scheduler: timeline-based reference model,
// ROM and arrow-sprite models, directed scenarios plus randomized waves.
`timescale 1ns / 1ps

module tb_arrow_scheduler;

  localparam int unsigned NS    = 24;
  localparam int unsigned WD    = 16;
  localparam int unsigned TK    = 4;
  localparam int unsigned RL    = 1;
  localparam logic [3:0]  START = 4'b1000;
  localparam int          NEVER = 32'h7fffffff;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    state_in = 4'h0;
  logic [3:0]    turn_in = 4'h0;
  logic          abort_in = 1'b0;
  logic [NS-1:0] slot_busy_in;
  logic [7:0]    pat_addr_out;
  logic [13:0]   pat_data_in;
  logic [NS-1:0] spawn_out;
  logic [1:0]    direction_out;
  logic [1:0]    speed_out;
  logic          inversed_out;
  logic          busy_out;
  logic          finished_out;
  logic [7:0]    spawn_count_out;

  always #5 clk = ~clk;

  arrow_scheduler #(
    .NUM_SLOTS  (NS),
    .WAVE_DEPTH (WD),
    .TICK_CYCLES(TK),
    .ROM_LATENCY(RL),
    .START_STATE(START)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .state_in       (state_in),
    .turn_in        (turn_in),
    .abort_in       (abort_in),
    .slot_busy_in   (slot_busy_in),
    .pat_addr_out   (pat_addr_out),
    .pat_data_in    (pat_data_in),
    .spawn_out      (spawn_out),
    .direction_out  (direction_out),
    .speed_out      (speed_out),
    .inversed_out   (inversed_out),
    .busy_out       (busy_out),
    .finished_out   (finished_out),
    .spawn_count_out(spawn_count_out)
  );

  // Pattern ROM with RL cycles of address-to-data latency.
  logic [13:0] rom [256];
  logic [7:0]  addr_pipe [RL];
  always @(posedge clk) begin
    addr_pipe[0] <= pat_addr_out;
    for (int i = 1; i < RL; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign pat_data_in = rom[addr_pipe[RL-1]];

  logic [NS-1:0] sprite_busy = '0;
  logic [NS-1:0] force_mask = '0;
  assign slot_busy_in = sprite_busy | force_mask;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state (timeline of capture/launch/drain cycles).
  bit            mvalid = 1'b0;
  logic [3:0]    m_prev = 4'h0;
  bit            m_active = 1'b0;
  logic [3:0]    m_turn = 4'h0;
  int            m_idx = 0;
  int            m_cap_at = NEVER;
  int            m_launch_at = NEVER;
  int            m_drain_at = NEVER;
  bit            m_draining = 1'b0;
  logic [13:0]   m_ent = '0;
  logic [NS-1:0] m_spawn = '0;
  logic [NS-1:0] m_spawn_prev = '0;
  logic [1:0]    m_dir = 2'b00;
  logic [1:0]    m_speed = 2'b00;
  logic          m_inv = 1'b0;
  logic          m_fin = 1'b0;
  int            m_count = 0;
  int            life [NS];
  logic [NS-1:0] busy_v;
  logic [NS-1:0] free_v;
  bit            start_v;
  int            pick;

  // Monitors used by the directed scenarios.
  int            dut_spawns = 0;
  int            dut_fins = 0;
  int            busy_cycles = 0;
  bit            page_bad = 1'b0;
  logic [3:0]    page_turn = 4'h0;

  // Model step and per-cycle comparison, just after each rising edge.
  initial begin
    for (int i = 0; i < NS; i++) life[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      busy_v       = sprite_busy | force_mask;
      m_spawn_prev = m_spawn;
      m_spawn      = '0;
      m_dir        = 2'b00;
      m_speed      = 2'b00;
      m_inv        = 1'b0;
      m_fin        = 1'b0;
      if (!rst) begin
        mvalid       = 1'b1;
        m_prev       = 4'h0;
        m_active     = 1'b0;
        m_turn       = 4'h0;
        m_idx        = 0;
        m_count      = 0;
        m_draining   = 1'b0;
        m_spawn_prev = '0;
      end else begin
        start_v = (state_in == START) && (m_prev != START);
        if (m_active && abort_in) begin
          m_active = 1'b0;
        end else if (!m_active) begin
          if (start_v && !abort_in) begin
            m_active    = 1'b1;
            m_turn      = turn_in;
            m_idx       = 0;
            m_count     = 0;
            m_draining  = 1'b0;
            m_cap_at    = cyc + 1 + RL;
            m_launch_at = NEVER;
          end
        end else if (!m_draining) begin
          if (cyc == m_cap_at) begin
            m_ent       = rom[{m_turn, 4'(m_idx)}];
            m_launch_at = cyc + int'(m_ent[13:6]) * TK + 2;
          end else if (cyc >= m_launch_at) begin
            free_v = ~busy_v & ~m_spawn_prev;
            if (free_v != '0) begin
              pick = 0;
              for (int i = NS - 1; i >= 0; i--) if (free_v[i]) pick = i;
              m_spawn[pick] = 1'b1;
              m_dir   = m_ent[5:4];
              m_speed = m_ent[3:2];
              m_inv   = m_ent[1];
              if (m_count < 255) m_count++;
              if (m_ent[0] || (m_idx == WD - 1)) begin
                m_draining = 1'b1;
                m_drain_at = cyc + 2;
              end else begin
                m_idx++;
                m_cap_at    = cyc + 1 + RL;
                m_launch_at = NEVER;
              end
            end
          end
        end else if ((cyc >= m_drain_at) && (busy_v == '0)) begin
          m_fin    = 1'b1;
          m_active = 1'b0;
        end
        m_prev = state_in;
      end
      // Arrow sprites: busy from the cycle after a launch, for a random lifetime.
      for (int i = 0; i < NS; i++) begin
        if (!rst) life[i] = 0;
        else if (m_spawn_prev[i]) life[i] = $urandom_range(8, 30);
        else if (life[i] > 0) life[i]--;
        sprite_busy[i] = (life[i] != 0);
      end
      if (mvalid) begin
        check("spawn_out", 64'(spawn_out), 64'(m_spawn));
        check("direction_out", 64'(direction_out), 64'(m_dir));
        check("speed_out", 64'(speed_out), 64'(m_speed));
        check("inversed_out", 64'(inversed_out), 64'(m_inv));
        check("busy_out", 64'(busy_out), 64'(m_active));
        check("finished_out", 64'(finished_out), 64'(m_fin));
        check("spawn_count_out", 64'(spawn_count_out), 64'(m_count));
        check("pat_addr_out", 64'(pat_addr_out), 64'({m_turn, 4'(m_idx)}));
      end
      if (spawn_out != '0) dut_spawns++;
      if (finished_out) dut_fins++;
      if (busy_out) busy_cycles++;
      if (busy_out && (pat_addr_out[7:4] != page_turn)) page_bad = 1'b1;
    end
  end

  task automatic start_wave(input logic [3:0] t);
    @(negedge clk);
    state_in = 4'h0;
    @(negedge clk);
    state_in  = START;
    turn_in   = t;
    page_turn = t;
    @(negedge clk);
    page_bad = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy_out && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(busy_out), 64'd0);
  endtask

  initial begin
    int k, s0, f0, b0;
    logic [3:0] t;
    for (int a = 0; a < 256; a++) begin
      rom[a] = {8'($urandom_range(0, 3)), 2'($urandom), 2'($urandom), 1'($urandom),
                1'($urandom_range(0, 3) == 0)};
    end
    rom[8'h30] = {8'd2, 2'b01, 2'b10, 1'b0, 1'b0};
    rom[8'h31] = {8'd0, 2'b10, 2'b01, 1'b1, 1'b1};
    rom[8'h50] = {8'd0, 2'b11, 2'b11, 1'b1, 1'b1};
    for (int i = 0; i < 16; i++) begin
      rom[{4'h7, 4'(i)}] = {8'($urandom_range(0, 1)), 2'(i), 2'(i >> 2), 1'(i), 1'b0};
    end
    rom[8'h90] = {8'd0, 2'b00, 2'b01, 1'b0, 1'b0};
    rom[8'h91] = {8'd5, 2'b01, 2'b00, 1'b0, 1'b0};
    rom[8'h92] = {8'd0, 2'b10, 2'b10, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy_out), 64'd0);
    check("reset_count", 64'(spawn_count_out), 64'd0);
    check("reset_addr", 64'(pat_addr_out), 64'd0);

    // Basic wave: D=2 on slot 0 at capture+10, then D=0 on slot 1.
    f0 = dut_fins;
    start_wave(4'd3);
    check("t1_busy_after_start", 64'(busy_out), 64'd1);
    check("t1_addr_after_start", 64'(pat_addr_out), 64'h30);
    k = 1;
    while ((spawn_out == '0) && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    check("t1_first_spawn_edge", 64'(k), 64'd13);
    check("t1_first_slot", 64'(spawn_out), 64'h1);
    check("t1_first_dir", 64'(direction_out), 64'h1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((spawn_out == '0) && (k < 100));
    check("t1_second_spawn_gap", 64'(k), 64'd4);
    check("t1_second_slot", 64'(spawn_out), 64'h2);
    check("t1_second_dir", 64'(direction_out), 64'h2);
    wait_idle("t1_done", 500);
    check("t1_count", 64'(spawn_count_out), 64'd2);
    check("t1_finished_once", 64'(dut_fins - f0), 64'd1);

    // Slot exhaustion: wave stalls until bit 5 frees up.
    force_mask = '1;
    s0 = dut_spawns;
    start_wave(4'd5);
    repeat (20) @(negedge clk);
    check("t2_stalled_busy", 64'(busy_out), 64'd1);
    check("t2_no_spawn", 64'(dut_spawns - s0), 64'd0);
    force_mask[5] = 1'b0;
    @(negedge clk);
    check("t2_slot5", 64'(spawn_out), 64'h20);
    check("t2_count", 64'(spawn_count_out), 64'd1);
    force_mask = '0;
    wait_idle("t2_done", 500);

    // Sixteen entries without last: stays on its page and drains after entry 15.
    s0 = dut_spawns;
    f0 = dut_fins;
    start_wave(4'd7);
    wait_idle("t3_done", 2000);
    check("t3_spawns", 64'(dut_spawns - s0), 64'd16);
    check("t3_count", 64'(spawn_count_out), 64'd16);
    check("t3_page", 64'(page_bad), 64'd0);
    check("t3_finished", 64'(dut_fins - f0), 64'd1);

    // Abort during the second entry's delay.
    start_wave(4'd9);
    k = 0;
    while ((spawn_out == '0) && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    check("t4_first_slot", 64'(spawn_out), 64'h1);
    repeat (6) @(negedge clk);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    check("t4_busy_drop", 64'(busy_out), 64'd0);
    check("t4_count_held", 64'(spawn_count_out), 64'd1);
    s0 = dut_spawns;
    f0 = dut_fins;
    repeat (60) @(negedge clk);
    check("t4_no_spawn", 64'(dut_spawns - s0), 64'd0);
    check("t4_no_finish", 64'(dut_fins - f0), 64'd0);
    start_wave(4'd9);
    check("t4_restart_addr", 64'(pat_addr_out), 64'h90);
    check("t4_restart_count", 64'(spawn_count_out), 64'd0);
    wait_idle("t4_done", 500);
    check("t4_final_count", 64'(spawn_count_out), 64'd3);

    // Abort beats a simultaneous start edge.
    @(negedge clk);
    state_in = 4'h0;
    @(negedge clk);
    state_in = START;
    turn_in  = 4'd2;
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_vs_start", 64'(busy_out), 64'd0);

    // Held start state gives no restart.
    b0 = busy_cycles;
    repeat (1000) @(negedge clk);
    check("t5_hold_no_restart", 64'(busy_cycles - b0), 64'd0);

    // Reset mid-wave, then restart on release with START_STATE present.
    start_wave(4'd7);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", 64'(busy_out), 64'd0);
    check("t5_rst_spawn", 64'(spawn_out), 64'd0);
    check("t5_rst_count", 64'(spawn_count_out), 64'd0);
    check("t5_rst_addr", 64'(pat_addr_out), 64'd0);
    check("t5_rst_finished", 64'(finished_out), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_restart_busy", 64'(busy_out), 64'd1);
    check("t5_restart_addr", 64'(pat_addr_out), 64'h70);
    wait_idle("t5_done", 2000);

    // Randomized waves with occasional aborts and partial slot blocking.
    for (int w = 0; w < 12; w++) begin
      t = 4'($urandom_range(0, 15));
      force_mask = ($urandom_range(0, 2) == 0) ? NS'($urandom_range(1, 15)) : '0;
      start_wave(t);
      k = 0;
      while (busy_out && (k < 4000)) begin
        abort_in = ($urandom_range(0, 149) == 0);
        if (k == 60) force_mask = '0;
        @(negedge clk);
        k++;
      end
      abort_in   = 1'b0;
      force_mask = '0;
      check("rand_wave_done", 64'(busy_out), 64'd0);
    end

    state_in = 4'h0;
    repeat (40) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
